// File: rtl/mem_responder.sv
// mem_responder: word-addressed unified instruction/data memory that answers
// MemRead/MemWrite requests with a fixed-latency wait-state handshake.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   MemRead    read request
//   MemWrite   write request
//   Address    byte address (must be word-aligned and below 4*DEPTH)
//   WriteData  store data
//   MemData    registered read data; changes only on a good read or reset
//   MemReady   one-cycle completion strobe
//   MemError   high with MemReady when a request was rejected
//   Busy       high while a request is outstanding (BUSY and RESP states)
//   LoadEn     preload write enable (honoured only while idle)
//   LoadAddr   preload word index
//   LoadData   preload data
module mem_responder #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 256,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  input  logic [ADDR_WIDTH-1:0]    Address,
  input  logic [DATA_WIDTH-1:0]    WriteData,
  output logic [DATA_WIDTH-1:0]    MemData,
  output logic                     MemReady,
  output logic                     MemError,
  output logic                     Busy,
  input  logic                     LoadEn,
  input  logic [$clog2(DEPTH)-1:0] LoadAddr,
  input  logic [DATA_WIDTH-1:0]    LoadData
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  write_q;
  logic                  err_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  bad_addr;
  logic                  req_one;
  logic                  req_both;
  logic                  accept;
  logic                  commit;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_widx;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Range check on the word index so the comparison never overflows DEPTH*4.
  assign bad_addr = (Address[1:0] != 2'b00) ||
                    ({2'b00, Address[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(DEPTH));
  assign req_one  = MemRead ^ MemWrite;
  assign req_both = MemRead & MemWrite;
  assign accept   = (state == IDLE) && !LoadEn && req_one;
  // A commit edge that coincides with reset is an abort, never a write.
  assign commit   = reset && (state == BUSY) && (cnt == '0);

  // Single memory write port shared by preload and committed stores.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = LoadAddr;
    mem_wdata = LoadData;
    if (reset && (state == IDLE) && LoadEn) begin
      mem_we = 1'b1;
    end else if (commit && write_q && !err_q) begin
      mem_we    = 1'b1;
      mem_widx  = idx_q;
      mem_wdata = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  // Request fields are latched at acceptance so BUSY ignores input changes.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= Address[IDX_W+1:2];
      wdata_q <= WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      MemData  <= '0;
      MemReady <= 1'b0;
      MemError <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      MemReady <= 1'b0;
      MemError <= 1'b0;
      case (state)
        IDLE: begin
          if (!LoadEn) begin
            if (req_both) begin
              // Conflicting request: respond immediately with an error.
              err_q    <= 1'b1;
              state    <= RESP;
              Busy     <= 1'b1;
              MemReady <= 1'b1;
              MemError <= 1'b1;
            end else if (req_one) begin
              write_q <= MemWrite;
              err_q   <= bad_addr;
              cnt     <= MemWrite ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
              state   <= BUSY;
              Busy    <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state    <= RESP;
            MemReady <= 1'b1;
            MemError <= err_q;
            if (!write_q && !err_q) begin
              MemData <= mem[idx_q];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
